// File: rtl/sparse_pe_core.sv
// sparse_pe_core: sparse activation x weight MAC into saturating
// per-channel accumulators, then a post-processed result stream.
module sparse_pe_core #(
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 6,
    parameter int IA_DEPTH = 16,
    parameter int W_DEPTH  = 32,
    parameter int K_OUT    = 4,
    parameter int ACC_W    = 20,
    parameter int OUT_W    = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic [$clog2(IA_DEPTH):0]             i_ia_len,
    input  logic [IA_DEPTH*DATA_W-1:0]            i_ia_data,
    input  logic [IA_DEPTH*IDX_W-1:0]             i_ia_c_idx,
    input  logic [$clog2(W_DEPTH):0]              i_w_len,
    input  logic [W_DEPTH*DATA_W-1:0]             i_w_data,
    input  logic [W_DEPTH*IDX_W-1:0]              i_w_c_idx,
    input  logic [W_DEPTH*($clog2(K_OUT)+1)-1:0]  i_w_k_idx,
    input  logic [4:0]                            i_shift,
    input  logic                                  i_relu,
    input  logic                                  i_out_ready,
    output logic                                  o_busy,
    output logic                                  o_out_valid,
    output logic [$clog2(K_OUT)-1:0]              o_out_k,
    output logic [OUT_W-1:0]                      o_out_data,
    output logic                                  o_done
);

    localparam int IA_AW = $clog2(IA_DEPTH);
    localparam int W_AW  = $clog2(W_DEPTH);
    localparam int IA_LW = IA_AW + 1;
    localparam int W_LW  = W_AW + 1;
    localparam int K_W   = $clog2(K_OUT);
    localparam int KI_W  = K_W + 1;
    localparam int P_W   = 2 * DATA_W;

    localparam logic signed [ACC_W:0] SUM_MAX =
        {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN =
        {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OMAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

    state_t state;

    logic signed [DATA_W-1:0] ia_val [IA_DEPTH];
    logic        [IDX_W-1:0]  ia_c   [IA_DEPTH];
    logic signed [DATA_W-1:0] w_val  [W_DEPTH];
    logic        [IDX_W-1:0]  w_c    [W_DEPTH];
    logic        [KI_W-1:0]   w_k    [W_DEPTH];
    logic signed [ACC_W-1:0]  acc    [K_OUT];

    logic [IA_LW-1:0] ia_len;
    logic [W_LW-1:0]  w_len;
    logic [IA_AW-1:0] i_cnt;
    logic [W_AW-1:0]  j_cnt;
    logic [K_W-1:0]   out_k;
    logic [4:0]       shift_q;
    logic             relu_q;

    logic [IA_LW-1:0] ia_len_c;
    logic [W_LW-1:0]  w_len_c;

    always_comb begin
        ia_len_c = i_ia_len;
        w_len_c  = i_w_len;
        if (i_ia_len > IA_LW'(IA_DEPTH))
            ia_len_c = IA_LW'(IA_DEPTH);
        if (i_w_len > W_LW'(W_DEPTH))
            w_len_c = W_LW'(W_DEPTH);
    end

    logic signed [P_W-1:0]   prod;
    logic        [KI_W-1:0]  k_sel;
    logic                    hit;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_next;

    assign prod  = ia_val[i_cnt] * w_val[j_cnt];
    assign k_sel = w_k[j_cnt];
    assign hit   = (ia_c[i_cnt] == w_c[j_cnt]) &&
                   (k_sel < KI_W'(K_OUT));

    always_comb begin
        sum = (ACC_W+1)'(acc[k_sel[K_W-1:0]]) + (ACC_W+1)'(prod);
        acc_next = sum[ACC_W-1:0];
        if (sum > SUM_MAX)
            acc_next = SUM_MAX[ACC_W-1:0];
        else if (sum < SUM_MIN)
            acc_next = SUM_MIN[ACC_W-1:0];
    end

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] post;

    assign shifted = acc[out_k] >>> shift_q;

    always_comb begin
        post = shifted;
        if (relu_q && shifted[ACC_W-1])
            post = '0;
        if (!o_out_valid)
            o_out_data = '0;
        else if (post > OMAX)
            o_out_data = {1'b0, {(OUT_W-1){1'b1}}};
        else if (post < OMIN)
            o_out_data = {1'b1, {(OUT_W-1){1'b0}}};
        else
            o_out_data = post[OUT_W-1:0];
    end

    assign o_out_k = out_k;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ia_len      <= '0;
            w_len       <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            out_k       <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
            o_done      <= 1'b0;
            for (int n = 0; n < IA_DEPTH; n++) begin
                ia_val[n] <= '0;
                ia_c[n]   <= '0;
            end
            for (int n = 0; n < W_DEPTH; n++) begin
                w_val[n] <= '0;
                w_c[n]   <= '0;
                w_k[n]   <= '0;
            end
            for (int n = 0; n < K_OUT; n++)
                acc[n] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        for (int n = 0; n < IA_DEPTH; n++) begin
                            ia_val[n] <= i_ia_data[n*DATA_W +: DATA_W];
                            ia_c[n]   <= i_ia_c_idx[n*IDX_W +: IDX_W];
                        end
                        for (int n = 0; n < W_DEPTH; n++) begin
                            w_val[n] <= i_w_data[n*DATA_W +: DATA_W];
                            w_c[n]   <= i_w_c_idx[n*IDX_W +: IDX_W];
                            w_k[n]   <= i_w_k_idx[n*KI_W +: KI_W];
                        end
                        for (int n = 0; n < K_OUT; n++)
                            acc[n] <= '0;
                        ia_len  <= ia_len_c;
                        w_len   <= w_len_c;
                        shift_q <= i_shift;
                        relu_q  <= i_relu;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        out_k   <= '0;
                        o_busy  <= 1'b1;
                        if (ia_len_c != '0 && w_len_c != '0) begin
                            state <= CALC;
                        end else begin
                            state       <= DRAIN;
                            o_out_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (hit)
                        acc[k_sel[K_W-1:0]] <= acc_next;
                    if ({1'b0, j_cnt} == w_len - W_LW'(1)) begin
                        j_cnt <= '0;
                        if ({1'b0, i_cnt} == ia_len - IA_LW'(1)) begin
                            i_cnt       <= '0;
                            state       <= DRAIN;
                            o_out_valid <= 1'b1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (i_out_ready) begin
                        if (out_k == K_W'(K_OUT - 1)) begin
                            out_k       <= '0;
                            o_out_valid <= 1'b0;
                            o_done      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            out_k <= out_k + 1'b1;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sparse_pe_core.md
# sparse_pe_core

Parametrised sparse processing element for the compressed-CNN datapath. Takes one batch of compressed input activations (value plus channel index) and one batch of compressed weights (value, input-channel index, output-channel index). For every activation/weight pair with matching input channel, it accumulates the product into the selected output-channel accumulator. It then streams the K_OUT post-processed results (shift, optional ReLU, saturate) to the output buffer over a valid/ready handshake.

## Interface
- DATA_W, 8: signed activation/weight width
- IDX_W, 6: channel-index width
- IA_DEPTH, 16: max activations per batch
- W_DEPTH, 32: max weights per batch
- K_OUT, 4: output channels (accumulators)
- ACC_W, 20: signed accumulator width
- OUT_W, 8: signed output width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  batch start; sampled only in IDLE
- i_ia_len  in  $clog2(IA_DEPTH)+1  valid activation count
- i_ia_data  in  IA_DEPTH x DATA_W  signed activation values
- i_ia_c_idx  in  IA_DEPTH x IDX_W  activation channel indices
- i_w_len  in  $clog2(W_DEPTH)+1  valid weight count
- i_w_data  in  W_DEPTH x DATA_W  signed weight values
- i_w_c_idx  in  W_DEPTH x IDX_W  weight input-channel indices
- i_w_k_idx  in  W_DEPTH x $clog2(K_OUT)+1  weight output-channel indices
- i_shift  in  5  arithmetic right shift applied at output
- i_relu  in  1  clamp negative results to 0
- i_out_ready  in  1  downstream ready
- o_busy  out  1  high in CALC, DRAIN, DONE
- o_out_valid  out  1  result valid
- o_out_k  out  $clog2(K_OUT)  channel of o_out_data
- o_out_data  out  OUT_W  signed result
- o_done  out  1  one-cycle batch-complete pulse

## Operation
- FSM states: IDLE, CALC, DRAIN, DONE.
- IDLE + i_start: latch all batch inputs, i_shift and i_relu, and clear all accumulators. Lengths are clamped to IA_DEPTH and W_DEPTH. Next state is CALC if both lengths are nonzero, else DRAIN.
- CALC: nested counters, i over activations (outer) and j over weights (inner), one pair per cycle, N = ia_len*w_len cycles. If c_idx[i]==w_c_idx[j] and w_k_idx[j]<K_OUT, then acc[w_k_idx[j]] += ia[i]*w[j]. After the last pair, go to DRAIN.
- Product width: 2*DATA_W signed, sign-extended. Accumulation saturates at +/-(2^(ACC_W-1)) bounds and stays saturated.
- Duplicate indices are legal; every match accumulates. A pair with w_k_idx >= K_OUT is skipped, but the cycle is still consumed.
- DRAIN: present k = 0..K_OUT-1 in order. o_out_data = sat_OUT_W(relu ? max(acc>>>shift, 0) : acc>>>shift). The shift is arithmetic (floor).
- A transfer occurs on an edge with valid&&ready. Advance k on each transfer. After the k=K_OUT-1 transfer, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored. Inputs are not sampled after the start edge.
- Reset (any state): FSM to IDLE, accumulators and counters cleared.

## Timing
- Reset values: o_busy=0, o_out_valid=0, o_out_k=0, o_out_data=0, o_done=0.
- All outputs are registered or decoded from registered state; no combinational path from i_out_ready to o_out_valid.
- Start edge at cycle 0 → CALC occupies cycles 1..N → o_out_valid first high in cycle N+1.
- With i_out_ready held high, one result per cycle; o_done high in cycle N+K_OUT+1; IDLE in cycle N+K_OUT+2. New i_start is accepted in that cycle.
- Zero length: o_out_valid high in cycle 1, all outputs 0 (ReLU/shift of 0).
- Ready low: o_out_valid stays high, o_out_k and o_out_data stay stable.

## Test plan
- Reset values: reset asserted mid-cycle (asynchronous) → all outputs 0 immediately; after release, o_busy=0.
- Basic batch, defaults, shift 0, ReLU off. Activations (c2,1),(c3,2). Weights (c2,4,k0),(c3,5,k0),(c3,6,k1),(c7,7,k2). → Outputs k0=14, k1=12, k2=0, k3=0. valid first in cycle 9; o_done in cycle 13.
- Sign, shift and ReLU: single pair a=3, w=-5, k0.
  - ReLU off, shift 0 → -15.
  - Shift 1 → -8.
  - ReLU on → 0.
  - k1..k3 → 0.
- Saturation: ia_len=16, w_len=32, all values -128, all c0/k0. → Accumulator clamps to 524287; output 127 with shift 0 and with shift 12.
- Backpressure: basic batch with ready low for 5 cycles at k=1. → valid held; k=1 and data=12 stable; no skipped or duplicated k; o_done delayed 5 cycles.
- Control boundaries:
  - ia_len=0 → four zeros, o_done in cycle 5.
  - i_start pulsed during CALC → ignored; results unchanged.
  - Reset during CALC, then new batch → results match a clean run.
